// File: rtl/ysyx_22050550_exu_mc.sv
// Multi-cycle RV64IM execute unit: single-cycle ALU ops, iterative shift-add multiply
// and restoring divide (one bit per cycle), with a valid/ready result handshake.
module ysyx_22050550_exu_mc #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rden_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      o_rd,
    output logic            o_wen,
    output logic [XLEN-1:0] o_wdata,
    output logic            e_break,
    output logic            busy
);
    localparam int unsigned SW = $clog2(XLEN);
    localparam logic [6:0] OpImm = 7'b0010011;
    localparam logic [6:0] OpReg = 7'b0110011;
    localparam logic [6:0] OpSys = 7'b1110011;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;
    state_e state_q, state_d;

    // Issue-side decode
    logic [2:0]      f3;
    logic [SW-1:0]   shamt;
    logic            is_op, alu_ok, m_ok, is_ebreak, wen_req, sgn_div, op1_neg, op2_neg;
    logic [XLEN-1:0] alu_res, mag1, mag2;
    logic signed [XLEN-1:0] sra_res;

    assign f3        = instr_i[14:12];
    assign shamt     = op2_i[SW-1:0];
    assign is_op     = (instr_i[6:0] == OpReg);
    assign alu_ok    = (instr_i[6:0] == OpImm) | (is_op & ~instr_i[25]);
    assign m_ok      = is_op & instr_i[25] & (f3 != 3'b001) & (f3 != 3'b010);
    assign is_ebreak = (instr_i[6:0] == OpSys) & (instr_i[31:20] == 12'h001);
    assign wen_req   = rden_i & (rd_addr_i != 5'd0);
    assign sra_res   = $signed(op1_i) >>> shamt;
    assign sgn_div   = ~f3[0];
    assign op1_neg   = sgn_div & op1_i[XLEN-1];
    assign op2_neg   = sgn_div & op2_i[XLEN-1];
    assign mag1      = op1_neg ? -op1_i : op1_i;
    assign mag2      = op2_neg ? -op2_i : op2_i;

    always_comb begin
        alu_res = '0;
        case (f3)
            3'b000: alu_res = (is_op & instr_i[30]) ? op1_i - op2_i : op1_i + op2_i;
            3'b001: alu_res = op1_i << shamt;
            3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, op1_i < op2_i};
            3'b100: alu_res = op1_i ^ op2_i;
            3'b101: alu_res = instr_i[30] ? sra_res : op1_i >> shamt;
            3'b110: alu_res = op1_i | op2_i;
            3'b111: alu_res = op1_i & op2_i;
        endcase
    end

    // Iterative datapath: p_q holds {acc, multiplier} for mul, {remainder, quotient} for div
    logic [2*XLEN-1:0] p_q, p_next;
    logic [XLEN-1:0]   a_q, dividend_q, rem_new, quo, rem, m_res;
    logic [XLEN:0]     mul_sum, rem_shift;
    logic [SW-1:0]     cnt_q;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic              wen_q, neg_q, dsign_q, dzero_q, div_ge, last;

    assign last = (cnt_q == SW'(XLEN - 1));

    always_comb begin
        mul_sum   = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, a_q} : '0);
        rem_shift = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
        div_ge    = (rem_shift >= {1'b0, a_q});
        rem_new   = div_ge ? XLEN'(rem_shift - {1'b0, a_q}) : rem_shift[XLEN-1:0];
        p_next    = f3_q[2] ? {rem_new, p_q[XLEN-2:0], div_ge} : {mul_sum, p_q[XLEN-1:1]};
        quo       = p_next[XLEN-1:0];
        rem       = p_next[2*XLEN-1:XLEN];
        if (dzero_q) begin
            quo = '1;
            rem = dividend_q;
        end else begin
            if (neg_q)   quo = -quo;
            if (dsign_q) rem = -rem;
        end
        if (f3_q[2]) m_res = f3_q[1] ? rem : quo;
        else         m_res = f3_q[1] ? p_next[2*XLEN-1:XLEN] : p_next[XLEN-1:0];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = m_ok ? StCalc : StDone;
            StCalc:  if (last) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            p_q        <= '0;
            a_q        <= '0;
            dividend_q <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            wen_q      <= 1'b0;
            neg_q      <= 1'b0;
            dsign_q    <= 1'b0;
            dzero_q    <= 1'b0;
            o_rd       <= '0;
            o_wen      <= 1'b0;
            o_wdata    <= '0;
            e_break    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: if (in_valid) begin
                    f3_q       <= f3;
                    rd_q       <= rd_addr_i;
                    wen_q      <= wen_req;
                    cnt_q      <= '0;
                    a_q        <= f3[2] ? mag2 : op2_i;
                    p_q        <= {{XLEN{1'b0}}, f3[2] ? mag1 : op1_i};
                    neg_q      <= op1_neg ^ op2_neg;
                    dsign_q    <= op1_neg;
                    dzero_q    <= (op2_i == '0);
                    dividend_q <= op1_i;
                    o_wen      <= alu_ok & wen_req;
                    o_rd       <= (alu_ok & wen_req) ? rd_addr_i : 5'd0;
                    o_wdata    <= alu_ok ? alu_res : '0;
                    e_break    <= is_ebreak;
                end
                StCalc: begin
                    p_q   <= p_next;
                    cnt_q <= cnt_q + SW'(1);
                    if (last) begin
                        cnt_q   <= '0;
                        o_wdata <= m_res;
                        o_wen   <= wen_q;
                        o_rd    <= wen_q ? rd_q : 5'd0;
                    end
                end
                StDone: if (out_ready) begin
                    o_rd    <= '0;
                    o_wen   <= 1'b0;
                    o_wdata <= '0;
                    e_break <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);

    // PC and register-field bits are carried by the pipeline but not needed here
    logic unused_bits;
    assign unused_bits = ^{pc_i, instr_i[19:15], instr_i[11:7]};
endmodule

// File: tb/tb_ysyx_22050550_exu_mc.sv
// Bench for ysyx_22050550_exu_mc: directed vector table, reset corner sequences and
// randomized ops checked against an arithmetic reference model.
module tb_ysyx_22050550_exu_mc;
    localparam int XLEN = 64;
    localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, rden_i, out_valid, out_ready, o_wen, e_break, busy;
    logic [63:0] pc_i, op1_i, op2_i, o_wdata;
    logic [31:0] instr_i;
    logic [4:0]  rd_addr_i, o_rd;

    int checks = 0;
    int errors = 0;

    ysyx_22050550_exu_mc #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc_i),
        .instr_i(instr_i), .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i),
        .rden_i(rden_i), .out_valid(out_valid), .out_ready(out_ready), .o_rd(o_rd),
        .o_wen(o_wen), .o_wdata(o_wdata), .e_break(e_break), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic        rden;
        logic [63:0] wd;
        logic        wen;
        logic [4:0]  ord;
        logic        eb;
        int          lat;
        int          hold;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 10'd0, f3, 5'd0, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'd0, f3, 5'd0, 7'b0010011};
    endfunction

    // Reference model: RISC-V semantics using native wide arithmetic
    function automatic void model(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                                  input logic [4:0] rd, input logic rden,
                                  output logic [63:0] wd, output logic wen,
                                  output logic [4:0] ord, output logic eb, output int lat);
        logic [6:0]   opc;
        logic [2:0]   f3;
        logic [127:0] prod;
        longint       sa, sb, t;
        int           sh;
        logic         sup;
        opc = ins[6:0]; f3 = ins[14:12];
        sa = a; sb = b; sh = int'(b[5:0]);
        wd = 64'd0; eb = 1'b0; sup = 1'b1; lat = 1;
        if (opc == 7'b0010011 || (opc == 7'b0110011 && !ins[25])) begin
            case (f3)
                3'd0: wd = (opc == 7'b0110011 && ins[30]) ? a - b : a + b;
                3'd1: wd = a << sh;
                3'd2: wd = (sa < sb) ? 64'd1 : 64'd0;
                3'd3: wd = (a < b) ? 64'd1 : 64'd0;
                3'd4: wd = a ^ b;
                3'd5: begin
                    if (ins[30]) begin t = sa >>> sh; wd = t; end
                    else wd = a >> sh;
                end
                3'd6: wd = a | b;
                3'd7: wd = a & b;
            endcase
        end else if (opc == 7'b0110011) begin
            lat  = 65;
            prod = {64'd0, a} * {64'd0, b};
            case (f3)
                3'd0: wd = prod[63:0];
                3'd3: wd = prod[127:64];
                3'd4: begin
                    if (b == 0) wd = ONES;
                    else if (a == MIN && sb == -1) wd = a;
                    else begin t = sa / sb; wd = t; end
                end
                3'd5: wd = (b == 0) ? ONES : a / b;
                3'd6: begin
                    if (b == 0) wd = a;
                    else if (a == MIN && sb == -1) wd = 64'd0;
                    else begin t = sa % sb; wd = t; end
                end
                3'd7: wd = (b == 0) ? a : a % b;
                default: begin sup = 1'b0; lat = 1; end
            endcase
        end else if (opc == 7'b1110011 && ins[31:20] == 12'h001) begin
            eb = 1'b1; sup = 1'b0;
        end else begin
            sup = 1'b0;
        end
        wen = rden && sup && (rd != 5'd0);
        ord = wen ? rd : 5'd0;
    endfunction

    task automatic junk_inputs();
        in_valid  = 1'($urandom_range(0, 1));
        instr_i   = $urandom;
        op1_i     = {$urandom, $urandom};
        op2_i     = {$urandom, $urandom};
        rd_addr_i = 5'($urandom);
        rden_i    = 1'($urandom);
    endtask

    task automatic run(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, " in_ready idle"}, {63'd0, in_ready}, 64'd1);
        instr_i = v.instr; op1_i = v.a; op2_i = v.b; rd_addr_i = v.rd; rden_i = v.rden;
        pc_i = {$urandom, $urandom}; in_valid = 1'b1;
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 200) begin
            junk_inputs();
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(v.lat));
        chk({tag, " wdata"}, o_wdata, v.wd);
        chk({tag, " wen"}, {63'd0, o_wen}, {63'd0, v.wen});
        chk({tag, " rd"}, {59'd0, o_rd}, {59'd0, v.ord});
        chk({tag, " ebreak"}, {63'd0, e_break}, {63'd0, v.eb});
        for (int i = 0; i < v.hold; i++) begin
            junk_inputs();
            @(negedge clk);
            chk({tag, " held valid"}, {63'd0, out_valid}, 64'd1);
            chk({tag, " held wdata"}, o_wdata, v.wd);
            chk({tag, " held in_ready"}, {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        chk({tag, " valid after hs"}, {63'd0, out_valid}, 64'd0);
        chk({tag, " in_ready after hs"}, {63'd0, in_ready}, 64'd1);
        chk({tag, " ebreak after hs"}, {63'd0, e_break}, 64'd0);
    endtask

    initial begin
        vec_t        tbl[$];
        vec_t        v;
        logic [31:0] pool[$];
        int          seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; rden_i = 1'b0;
        instr_i = '0; op1_i = '0; op2_i = '0; rd_addr_i = '0; pc_i = '0;
        repeat (2) @(negedge clk);
        chk("reset out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset wdata", o_wdata, 64'd0);
        chk("reset wen", {63'd0, o_wen}, 64'd0);
        chk("reset ebreak", {63'd0, e_break}, 64'd0);
        chk("reset in_ready", {63'd0, in_ready}, 64'd1);
        rst = 1'b0;

        // instr, a, b, rd, rden, wd, wen, ord, eb, lat, hold
        tbl.push_back('{itype(12'd7, 3'd0), 64'd5, 64'd7, 5'd3, 1'b1, 64'd12, 1'b1, 5'd3, 1'b0, 1, 0});
        tbl.push_back('{rtype(7'h20, 3'd0), 64'd3, 64'd5, 5'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE,
                        1'b1, 5'd4, 1'b0, 1, 3});
        tbl.push_back('{rtype(7'h01, 3'd0), ONES, 64'd2, 5'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE,
                        1'b1, 5'd5, 1'b0, 65, 0});
        tbl.push_back('{rtype(7'h01, 3'd3), ONES, 64'd2, 5'd6, 1'b1, 64'd1, 1'b1, 5'd6, 1'b0, 65, 0});
        tbl.push_back('{rtype(7'h01, 3'd5), 64'd100, 64'd0, 5'd7, 1'b1, ONES, 1'b1, 5'd7, 1'b0, 65, 0});
        tbl.push_back('{rtype(7'h01, 3'd7), 64'd100, 64'd0, 5'd8, 1'b1, 64'd100, 1'b1, 5'd8, 1'b0, 65, 1});
        tbl.push_back('{rtype(7'h01, 3'd4), MIN, ONES, 5'd9, 1'b1, MIN, 1'b1, 5'd9, 1'b0, 65, 0});
        tbl.push_back('{rtype(7'h01, 3'd6), 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, 1'b1, ONES,
                        1'b1, 5'd10, 1'b0, 65, 0});
        tbl.push_back('{rtype(7'h01, 3'd4), 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd11, 1'b1,
                        64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 5'd11, 1'b0, 65, 0});
        tbl.push_back('{32'h0010_0073, 64'd1, 64'd2, 5'd7, 1'b1, 64'd0, 1'b0, 5'd0, 1'b1, 1, 2});
        tbl.push_back('{itype(12'd7, 3'd0), 64'd5, 64'd7, 5'd0, 1'b1, 64'd12, 1'b0, 5'd0, 1'b0, 1, 0});
        tbl.push_back('{rtype(7'h20, 3'd5), MIN, 64'd4, 5'd12, 1'b1, 64'hF800_0000_0000_0000,
                        1'b1, 5'd12, 1'b0, 1, 0});
        tbl.push_back('{rtype(7'h00, 3'd2), ONES, 64'd1, 5'd13, 1'b1, 64'd1, 1'b1, 5'd13, 1'b0, 1, 0});
        tbl.push_back('{rtype(7'h00, 3'd3), ONES, 64'd1, 5'd14, 1'b1, 64'd0, 1'b1, 5'd14, 1'b0, 1, 0});
        tbl.push_back('{rtype(7'h01, 3'd1), 64'd3, 64'd3, 5'd15, 1'b1, 64'd0, 1'b0, 5'd0, 1'b0, 1, 0});
        tbl.push_back('{itype(12'h404, 3'd5), 64'hF0, 64'h404, 5'd16, 1'b1, 64'hF, 1'b1, 5'd16,
                        1'b0, 1, 0});
        tbl.push_back('{rtype(7'h00, 3'd0), 64'd1, 64'd2, 5'd17, 1'b0, 64'd3, 1'b0, 5'd0, 1'b0, 1, 0});
        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of a divu: result must never appear
        @(negedge clk);
        instr_i = rtype(7'h01, 3'd5); op1_i = 64'd1000; op2_i = 64'd7;
        rd_addr_i = 5'd1; rden_i = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("divu mid busy", {63'd0, busy}, 64'd1);
        rst = 1'b1; in_valid = 1'b1; instr_i = itype(12'd1, 3'd0);
        @(negedge clk);
        chk("rst calc busy", {63'd0, busy}, 64'd0);
        chk("rst calc in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst calc out_valid", {63'd0, out_valid}, 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst calc no result", 64'(seen), 64'd0);

        // Reset while an ebreak result is pending
        @(negedge clk);
        instr_i = 32'h0010_0073; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ebreak pending", {63'd0, e_break}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst done valid", {63'd0, out_valid}, 64'd0);
        chk("rst done ebreak", {63'd0, e_break}, 64'd0);
        chk("rst done wdata", o_wdata, 64'd0);

        // Randomized ops against the reference model
        for (int f = 0; f < 8; f++) begin
            pool.push_back(rtype((f == 0 || f == 5) ? 7'h20 : 7'h00, 3'(f)));
            pool.push_back(rtype(7'h00, 3'(f)));
            pool.push_back(rtype(7'h01, 3'(f)));
            pool.push_back(itype((f == 5) ? 12'h400 : 12'h000, 3'(f)));
        end
        pool.push_back(32'h0010_0073);
        pool.push_back(32'h0000_3003);
        for (int n = 0; n < 50; n++) begin
            v.instr = pool[$urandom_range(0, pool.size() - 1)];
            for (int k = 0; k < 2; k++) begin
                logic [63:0] x;
                case ($urandom_range(0, 5))
                    0: x = 64'd0;
                    1: x = ONES;
                    2: x = MIN;
                    3: x = 64'($urandom_range(0, 20));
                    default: x = {$urandom, $urandom};
                endcase
                if (k == 0) v.a = x; else v.b = x;
            end
            v.rd   = 5'($urandom);
            v.rden = 1'($urandom);
            v.hold = $urandom_range(0, 2);
            model(v.instr, v.a, v.b, v.rd, v.rden, v.wd, v.wen, v.ord, v.eb, v.lat);
            run(v, $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
